// File: rtl/rv_mc_pkg.sv
// Shared encodings for the multicycle RV32I control sequencer:
// state codes, opcodes, ALU/immediate/mux select values.
package rv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [1:0] imm_for_op(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_SW:   imm = IMM_S;
      OP_BEQ:  imm = IMM_B;
      OP_JAL:  imm = IMM_J;
      default: imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU control decode: fixed add/sub requests or funct3/funct7-driven operation.
module alu_decoder
  import rv_mc_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  // funct3 codes outside the supported set fall back to add rather than trapping
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multicycle RV32I datapath with a shared,
// ready-handshaked memory; drives every datapath enable and select.
module multicycle_control_fsm
  import rv_mc_pkg::*;
#(
  parameter logic [3:0] RESET_STATE     = 4'd0,
  parameter bit         TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic [2:0] alu_control,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_e  state_q, state_d;
  logic    illegal_q, illegal_d;

  alu_op_e alu_op_s;
  logic    pc_update_s, branch_s;
  logic    mem_read_s, mem_write_s, ir_write_s, reg_write_s, retire_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= state_e'(RESET_STATE);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_comb begin
    pc_update_s = 1'b0;
    branch_s    = 1'b0;
    adr_src     = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    retire_s    = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RD2;
    imm_src     = IMM_I;
    alu_op_s    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b   = SRCB_FOUR;
        result_src  = RES_ALURESULT;
        ir_write_s  = mem_ready;
        pc_update_s = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = imm_for_op(op);
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        mem_read_s = 1'b1;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
        retire_s    = mem_ready;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_op_s  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op_s  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RD1;
        alu_op_s  = ALUOP_SUB;
        branch_s  = 1'b1;
        retire_s  = 1'b1;
      end
      S_JAL: begin
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_FOUR;
        pc_update_s = 1'b1;
      end
      default: begin
        pc_update_s = 1'b0;
      end
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op_s),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

  // Enables are gated by reset itself so nothing fires while reset is still low
  assign pc_write  = reset & (pc_update_s | (branch_s & zero));
  assign mem_read  = reset & mem_read_s;
  assign mem_write = reset & mem_write_s;
  assign ir_write  = reset & ir_write_s;
  assign reg_write = reset & reg_write_s;
  assign retire    = reset & retire_s;
  assign illegal   = illegal_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench: per-instruction expected cycle traces built from the
// instruction-level rules, compared cycle by cycle against the sequencer.
module tb_multicycle_control_fsm;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;

  logic clk = 1'b0;
  logic reset, funct7b5, zero, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, retire, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;

  typedef struct packed {
    logic pcw; logic adr; logic mrd; logic mw; logic irw;
    logic [1:0] rs; logic [1:0] asa; logic [1:0] asb; logic [1:0] imm;
    logic rw; logic [2:0] alu; logic ret; logic ill;
  } outs_t;
  typedef struct packed { logic [3:0] st; logic mr; outs_t o; } step_t;

  step_t q[$];
  int exp_lat;
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic cur_f7, cur_z;
  int n_checks = 0;
  int n_errors = 0;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .reg_write(reg_write), .alu_control(alu_control),
    .retire(retire), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_checks++;
    if (obs_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs_v, exp_v, $time);
    end
  endtask

  function automatic outs_t sample_outs();
    outs_t o;
    o.pcw = pc_write;  o.adr = adr_src;   o.mrd = mem_read;  o.mw = mem_write;
    o.irw = ir_write;  o.rs = result_src; o.asa = alu_src_a; o.asb = alu_src_b;
    o.imm = imm_src;   o.rw = reg_write;  o.alu = alu_control;
    o.ret = retire;    o.ill = illegal;
    return o;
  endfunction

  function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic f7, input logic op5);
    case (f3)
      3'b000:  return (f7 & op5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] o7);
    return (o7 == T_LW) || (o7 == T_SW) || (o7 == T_R) || (o7 == T_I) ||
           (o7 == T_BEQ) || (o7 == T_JAL);
  endfunction

  function automatic step_t blank(input logic [3:0] s, input logic mr);
    step_t e = '0;
    e.st = s;
    e.mr = mr;
    return e;
  endfunction

  // Build the expected trace for one instruction: wf fetch stalls, wm memory stalls
  task automatic gen(input logic [6:0] o7, input logic [2:0] f3, input logic f7,
                     input logic z, input int wf, input int wm);
    step_t e;
    q.delete();
    cur_op = o7; cur_f3 = f3; cur_f7 = f7; cur_z = z;
    for (int i = 0; i <= wf; i++) begin
      e = blank(4'd0, i == wf);
      e.o.mrd = 1'b1; e.o.asb = 2'b10; e.o.rs = 2'b10;
      e.o.irw = (i == wf); e.o.pcw = (i == wf);
      q.push_back(e);
    end
    e = blank(4'd1, 1'($urandom));
    e.o.asa = 2'b01; e.o.asb = 2'b01;
    e.o.imm = (o7 == T_SW) ? 2'b01 : (o7 == T_BEQ) ? 2'b10 : (o7 == T_JAL) ? 2'b11 : 2'b00;
    q.push_back(e);
    exp_lat = 0;
    case (o7)
      T_LW, T_SW: begin
        e = blank(4'd2, 1'($urandom));
        e.o.asa = 2'b10; e.o.asb = 2'b01; e.o.imm = (o7 == T_SW) ? 2'b01 : 2'b00;
        q.push_back(e);
        for (int i = 0; i <= wm; i++) begin
          e = blank((o7 == T_LW) ? 4'd3 : 4'd5, i == wm);
          e.o.adr = 1'b1;
          if (o7 == T_LW) e.o.mrd = 1'b1;
          else begin e.o.mw = 1'b1; e.o.ret = (i == wm); end
          q.push_back(e);
        end
        if (o7 == T_LW) begin
          e = blank(4'd4, 1'($urandom));
          e.o.rs = 2'b01; e.o.rw = 1'b1; e.o.ret = 1'b1;
          q.push_back(e);
        end
        exp_lat = ((o7 == T_LW) ? 5 : 4) + wf + wm;
      end
      T_R, T_I, T_JAL: begin
        if (o7 == T_JAL) begin
          e = blank(4'd10, 1'($urandom));
          e.o.asa = 2'b01; e.o.asb = 2'b10; e.o.pcw = 1'b1;
        end else begin
          e = blank((o7 == T_R) ? 4'd6 : 4'd7, 1'($urandom));
          e.o.asa = 2'b10; e.o.asb = (o7 == T_R) ? 2'b00 : 2'b01;
          e.o.alu = ref_alu(f3, f7, o7 == T_R);
        end
        q.push_back(e);
        e = blank(4'd8, 1'($urandom));
        e.o.rw = 1'b1; e.o.ret = 1'b1;
        q.push_back(e);
        exp_lat = 4 + wf;
      end
      T_BEQ: begin
        e = blank(4'd9, 1'($urandom));
        e.o.asa = 2'b10; e.o.alu = 3'b001; e.o.pcw = z; e.o.ret = 1'b1;
        q.push_back(e);
        exp_lat = 3 + wf;
      end
      default: begin
        for (int i = 0; i < 12; i++) begin
          e = blank(4'd15, 1'($urandom));
          e.o.ill = 1'b1;
          q.push_back(e);
        end
      end
    endcase
  endtask

  task automatic run(input int n);
    int lat = 0;
    for (int k = 0; k < n && k < q.size(); k++) begin
      @(posedge clk); #1;
      reset = 1'b1; mem_ready = q[k].mr;
      op = cur_op; funct3 = cur_f3; funct7b5 = cur_f7; zero = cur_z;
      @(negedge clk);
      check_eq("state", 32'(state_o), 32'(q[k].st));
      check_eq("outs", 32'(sample_outs()), 32'(q[k].o));
      if (retire && lat == 0) lat = k + 1;
    end
    if (n >= q.size()) check_eq("latency", lat, exp_lat);
  endtask

  task automatic do_reset();
    outs_t r = '0;
    r.asb = 2'b10; r.rs = 2'b10;
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", 32'(state_o), 32'd0);
    check_eq("rst_outs", 32'(sample_outs()), 32'(r));
  endtask

  initial begin
    logic [6:0] ops [6];
    logic [6:0] bad;
    ops[0] = T_LW; ops[1] = T_SW; ops[2] = T_R; ops[3] = T_I; ops[4] = T_BEQ; ops[5] = T_JAL;
    reset = 1'b1; mem_ready = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    do_reset();
    gen(T_LW, 3'd2, 1'b0, 1'b0, 0, 0);   run(1000);
    gen(T_SW, 3'd2, 1'b0, 1'b0, 0, 3);   run(1000);
    gen(T_R, 3'd0, 1'b1, 1'b0, 0, 0);    run(1000);
    gen(T_I, 3'd0, 1'b1, 1'b0, 0, 0);    run(1000);
    gen(T_BEQ, 3'd0, 1'b0, 1'b1, 0, 0);  run(1000);
    gen(T_BEQ, 3'd0, 1'b0, 1'b0, 0, 0);  run(1000);
    gen(T_JAL, 3'd0, 1'b0, 1'b0, 1, 0);  run(1000);

    // Abort a store mid-MEMWRITE and make sure no write leaks out
    gen(T_SW, 3'd2, 1'b0, 1'b0, 0, 3);   run(4);
    #1 reset = 1'b0;
    #1;
    check_eq("abort_state", 32'(state_o), 32'd0);
    check_eq("abort_mw", 32'(mem_write), 32'd0);
    do_reset();
    gen(T_LW, 3'd0, 1'b0, 1'b0, 0, 1);   run(1000);

    for (int n = 0; n < 40; n++) begin
      gen(ops[$urandom_range(0, 5)], 3'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, 2), $urandom_range(0, 3));
      run(1000);
    end

    gen(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0); run(1000);
    do_reset();
    bad = 7'($urandom);
    while (is_legal(bad)) bad = 7'($urandom);
    gen(bad, 3'd0, 1'b0, 1'b0, 1, 0);     run(1000);
    do_reset();
    gen(T_R, 3'd7, 1'b0, 1'b0, 0, 0);    run(1000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
